// File: rtl/if_id_queue_pkg.sv
// Shared types for the IF->ID decoupling queue. Global macros (NOP, STOP) live in
// defines.v; this package holds only types, no constants.
package if_id_queue_pkg;

   // Encoded as {push, pop} so the control can cast the strobe pair directly.
   typedef enum logic [1:0] {
      Q_IDLE = 2'b00,
      Q_POP  = 2'b01,
      Q_PUSH = 2'b10,
      Q_BOTH = 2'b11
   } q_op_e;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for if_id_queue: DEPTH x WIDTH register array.
// One synchronous write port and one asynchronous read port; contents are never reset.
module if_id_queue_mem
   import if_id_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64,
   parameter int unsigned PTR_W = 2
) (
   input  logic             clk_i,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF->ID first-word-fall-through queue of {inst_addr, inst} pairs with flush on jump/interrupt.
// Define IF_ID_QUEUE_BYPASS_EN to forward fetch straight to decode when the queue is empty.
`ifndef NOP
`define NOP 32'h00000013
`endif
`ifndef STOP
`define STOP 1'b1
`endif
`ifndef NOSTOP
`define NOSTOP 1'b0
`endif

module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CNT_WIDTH  = $clog2(DEPTH) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_jump_i,
   input  logic                  flush_int_i,
   input  logic                  inst_valid_i,
   input  logic [ADDR_WIDTH-1:0] inst_addr_i,
   input  logic [DATA_WIDTH-1:0] inst_i,
   output logic                  inst_ready_o,
   input  logic                  id_ready_i,
   output logic                  inst_valid_o,
   output logic [ADDR_WIDTH-1:0] inst_addr_o,
   output logic [DATA_WIDTH-1:0] inst_o,
   output logic [CNT_WIDTH-1:0]  count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned ENT_W = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

   logic [CNT_WIDTH-1:0]  count_q;
   logic [PTR_W-1:0]      wr_ptr_q;
   logic [PTR_W-1:0]      rd_ptr_q;
   logic [ENT_W-1:0]      rd_entry;
   logic                  empty;
   logic                  flush;
   logic                  push;
   logic                  push_store;
   logic                  pop_store;
   logic                  bypass;
   q_op_e                 op;

   assign empty        = (count_q == '0);
   assign flush        = flush_jump_i | flush_int_i;
   assign inst_ready_o = (count_q != FULL_CNT);
   assign count_o      = count_q;
   assign push         = inst_valid_i & inst_ready_o;

`ifdef IF_ID_QUEUE_BYPASS_EN
   // Empty queue: present fetch directly; only store it if decode does not take it now.
   assign bypass     = empty & inst_valid_i & ~flush & ~rst_i;
   assign push_store = push & ~(bypass & id_ready_i);
`else
   assign bypass     = 1'b0;
   assign push_store = push;
`endif
   assign pop_store  = ~empty & id_ready_i;

   always_comb begin
      inst_valid_o = 1'b0;
      inst_addr_o  = '0;
      inst_o       = DATA_WIDTH'(`NOP);
      if (bypass) begin
         inst_valid_o = 1'b1;
         inst_addr_o  = inst_addr_i;
         inst_o       = inst_i;
      end else if (!empty) begin
         inst_valid_o = 1'b1;
         inst_addr_o  = rd_entry[ENT_W-1:DATA_WIDTH];
         inst_o       = rd_entry[DATA_WIDTH-1:0];
      end
   end

   always_comb begin
      op = q_op_e'({push_store, pop_store});
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (flush) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         unique case (op)
            Q_PUSH: begin
               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
               count_q  <= count_q + CNT_WIDTH'(1);
            end
            Q_POP: begin
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
               count_q  <= count_q - CNT_WIDTH'(1);
            end
            Q_BOTH: begin
               wr_ptr_q <= wr_ptr_q + PTR_W'(1);
               rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            default: ;
         endcase
      end
   end

   // A write in a flush or reset cycle lands in storage but is never counted, so it stays invisible.
   if_id_queue_mem #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W),
      .PTR_W (PTR_W)
   ) u_mem (
      .clk_i (clk_i),
      .we    (push_store),
      .waddr (wr_ptr_q),
      .wdata ({inst_addr_i, inst_i}),
      .raddr (rd_ptr_q),
      .rdata (rd_entry)
   );

endmodule
